// File: rtl/hid_kbd_pkg.sv
// Shared constants, event layout and FSM encoding for the HID keyboard event decoder.
package hid_kbd_pkg;

    localparam int KEY_SLOTS = 6;
    localparam int MOD_BITS  = 8;

    localparam logic [7:0] MOD_CODE_BASE = 8'hE0;
    localparam logic [7:0] ERR_ROLLOVER  = 8'h01;

    // Event word layout: {press, code}
    localparam int EVENT_W      = 9;
    localparam int EV_PRESS_BIT = 8;
    localparam int EV_CODE_LSB  = 0;
    localparam int EV_CODE_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_REL,
        ST_SCAN_PRS,
        ST_SCAN_MOD,
        ST_COMMIT
    } state_t;

    function automatic logic slot_empty(input logic [7:0] code, input logic ignore_err);
        return (code == 8'h00) || (ignore_err && (code >= 8'h01) && (code <= 8'h03));
    endfunction

    function automatic logic [EVENT_W-1:0] pack_event(input logic press, input logic [7:0] code);
        return {press, code};
    endfunction

endpackage

// File: rtl/hid_kbd_event_decoder_fifo.sv
// Synchronous event FIFO with occupancy tracking; head word is read straight from the array.
module hid_event_fifo
    import hid_kbd_pkg::*;
#(
    parameter int C_depth = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [EVENT_W-1:0] push_data,
    input  logic               pop,
    output logic [EVENT_W-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(C_depth);

    logic [EVENT_W-1:0] mem [C_depth];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [AW:0]        count_reg;
    logic               do_push;
    logic               do_pop;

    // Full is the registered occupancy, so a same-cycle pop never frees room for a push.
    assign full    = (count_reg == (AW+1)'(C_depth));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/hid_kbd_event_decoder.sv
// Turns successive HID boot keyboard reports into press/release events, one slot or bit per cycle.
module hid_kbd_event_decoder
    import hid_kbd_pkg::*;
#(
    parameter int C_fifo_depth       = 8,
    parameter int C_ignore_err_codes = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] hid_report,
    input  logic        hid_valid,
    output logic        event_valid,
    input  logic        event_ready,
    output logic [7:0]  event_code,
    output logic        event_press,
    output logic [7:0]  modifiers,
    output logic        busy,
    output logic        report_dropped,
    output logic        rollover_err
);

    localparam logic IGNORE_ERR = (C_ignore_err_codes != 0);

    state_t         state_reg;
    logic [2:0]     idx_reg;
    logic [63:0]    cur_reg;
    logic [63:0]    prev_reg;
    logic [7:0]     mod_reg;
    logic           dropped_reg;
    logic           rollover_reg;

    // Slot views padded to 8 entries so the 3-bit index never leaves the array.
    logic [7:0]           cur_slot  [8];
    logic [7:0]           prev_slot [8];
    logic [KEY_SLOTS-1:0] in_rollover;
    logic [KEY_SLOTS-1:0] cur_has_rel;
    logic [KEY_SLOTS-1:0] prev_has_prs;
    logic [KEY_SLOTS-1:0] cur_dup_below;
    logic [7:0]           rel_code;
    logic [7:0]           prs_code;

    logic                 need_push;
    logic                 ev_press;
    logic [7:0]           ev_code;
    logic                 last_step;
    logic                 step_ok;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [EVENT_W-1:0]   fifo_head;

    assign rel_code = prev_slot[idx_reg];
    assign prs_code = cur_slot[idx_reg];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slot_view
            if (gi < KEY_SLOTS) begin : g_real
                assign cur_slot[gi]  = cur_reg[8*(gi+2) +: 8];
                assign prev_slot[gi] = prev_reg[8*(gi+2) +: 8];
            end else begin : g_pad
                assign cur_slot[gi]  = 8'h00;
                assign prev_slot[gi] = 8'h00;
            end
        end

        for (genvar gi = 0; gi < KEY_SLOTS; gi++) begin : g_match
            assign in_rollover[gi]   = (hid_report[8*(gi+2) +: 8] == ERR_ROLLOVER);
            assign cur_has_rel[gi]   = (cur_slot[gi] == rel_code);
            assign prev_has_prs[gi]  = (prev_slot[gi] == prs_code);
            assign cur_dup_below[gi] = (3'(gi) < idx_reg) && (cur_slot[gi] == prs_code);
        end
    endgenerate

    always_comb begin
        need_push = 1'b0;
        ev_press  = 1'b0;
        ev_code   = 8'h00;
        last_step = 1'b0;
        case (state_reg)
            ST_SCAN_REL: begin
                need_push = !slot_empty(rel_code, IGNORE_ERR) && !(|cur_has_rel);
                ev_code   = rel_code;
                last_step = (idx_reg == 3'(KEY_SLOTS - 1));
            end
            ST_SCAN_PRS: begin
                need_push = !slot_empty(prs_code, IGNORE_ERR) && !(|prev_has_prs)
                            && !(|cur_dup_below);
                ev_press  = 1'b1;
                ev_code   = prs_code;
                last_step = (idx_reg == 3'(KEY_SLOTS - 1));
            end
            ST_SCAN_MOD: begin
                need_push = (cur_reg[idx_reg] != prev_reg[idx_reg]);
                ev_press  = cur_reg[idx_reg];
                ev_code   = MOD_CODE_BASE + {5'b00000, idx_reg};
                last_step = (idx_reg == 3'(MOD_BITS - 1));
            end
            default: ;
        endcase
    end

    // A needed push against a full FIFO freezes the scan position.
    assign step_ok   = !need_push || !fifo_full;
    assign fifo_push = need_push && !fifo_full;
    assign fifo_pop  = event_ready;

    hid_event_fifo #(
        .C_depth (C_fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (pack_event(ev_press, ev_code)),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= 3'd0;
            cur_reg      <= '0;
            prev_reg     <= '0;
            mod_reg      <= 8'h00;
            dropped_reg  <= 1'b0;
            rollover_reg <= 1'b0;
        end else begin
            rollover_reg <= 1'b0;
            if (hid_valid && (state_reg != ST_IDLE)) begin
                dropped_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (hid_valid) begin
                        cur_reg <= hid_report;
                        idx_reg <= 3'd0;
                        if (&in_rollover) begin
                            rollover_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_SCAN_REL;
                        end
                    end
                end
                ST_SCAN_REL: begin
                    if (step_ok) begin
                        idx_reg <= last_step ? 3'd0 : idx_reg + 3'd1;
                        if (last_step) begin
                            state_reg <= ST_SCAN_PRS;
                        end
                    end
                end
                ST_SCAN_PRS: begin
                    if (step_ok) begin
                        idx_reg <= last_step ? 3'd0 : idx_reg + 3'd1;
                        if (last_step) begin
                            state_reg <= ST_SCAN_MOD;
                        end
                    end
                end
                ST_SCAN_MOD: begin
                    if (step_ok) begin
                        idx_reg <= last_step ? 3'd0 : idx_reg + 3'd1;
                        if (last_step) begin
                            state_reg <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    prev_reg  <= cur_reg;
                    mod_reg   <= cur_reg[7:0];
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign event_valid    = !fifo_empty;
    assign event_press    = fifo_head[EV_PRESS_BIT];
    assign event_code     = fifo_head[EV_CODE_LSB +: EV_CODE_W];
    assign modifiers      = mod_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign report_dropped = dropped_reg;
    assign rollover_err   = rollover_reg;

endmodule

// File: doc/hid_kbd_event_decoder.md
Name: hid_kbd_event_decoder

Overview:
Sits directly downstream of the USB HID host. It consumes the 64-bit boot-protocol keyboard report and its one-cycle valid strobe. It compares each report against the previous one and emits discrete key press/release events through a small FIFO with a valid/ready handshake. Consumers include the display/debug path, a UART bridge or a soft CPU, so raw report snapshots are no longer needed.

Parameters:
C_fifo_depth, 8, event FIFO depth; power of two, 2..64
C_ignore_err_codes, 1, when 1, slot values 0x01..0x03 are treated as empty slots

Ports:
clk  in  1  single clock; the report producer runs on this same clock
reset  in  1  synchronous, active-high reset
hid_report  in  64  report; byte k = hid_report[8k+7:8k]; byte0 = modifiers, byte1 = reserved, bytes2..7 = keycode slots 0..5
hid_valid  in  1  one-cycle strobe; hid_report is valid in that cycle
event_valid  out  1  FIFO not empty
event_ready  in  1  consumer accepts the head event when event_valid=1
event_code  out  8  HID usage code of the head event
event_press  out  1  1 = press, 0 = release
modifiers  out  8  committed modifier byte
busy  out  1  FSM not in IDLE
report_dropped  out  1  sticky; a hid_valid arrived while busy=1; cleared only by reset
rollover_err  out  1  one-cycle pulse when a report is rejected for phantom state

Behaviour:
- Clock and reset: clk is the only clock. reset is synchronous and active-high.
- Reset values: event_valid=0, busy=0, modifiers=0, report_dropped=0, rollover_err=0, FIFO empty, prev report all-zero, FSM in IDLE.
- Reset mid-scan aborts the scan. Events not yet popped are discarded and prev is zeroed.
- FSM states: IDLE, SCAN_REL, SCAN_PRS, SCAN_MOD, COMMIT.
- IDLE: on hid_valid, latch the report into cur.
  - If all six slots equal 0x01 (ErrorRollOver), the report is rejected. rollover_err pulses the next cycle, prev is unchanged and the FSM stays in IDLE.
  - Otherwise the FSM moves to SCAN_REL with index 0.
- SCAN_REL (index 0..5): scans the prev slots.
  - A slot that is non-empty and not present in any cur slot pushes a release event {0, code}.
  - Then the FSM moves to SCAN_PRS with index 0.
- SCAN_PRS (index 0..5): scans the cur slots.
  - A slot that is non-empty, absent from prev, and not equal to any lower-index cur slot pushes a press event {1, code}.
  - Duplicate slots therefore yield one event.
- SCAN_MOD (bit 0..7): each bit where cur[0] differs from prev[0] pushes {cur bit, 8'hE0+bit}.
- COMMIT: prev <= cur, modifiers <= cur byte0, then IDLE.
- Scan rate: one slot/bit per cycle. Without stalls, busy is high for exactly 21 cycles after the accepting hid_valid edge.
- Stall: if a push is needed while the FIFO is full, the FSM holds its state and index until a slot frees.
  - Full is evaluated before the same-cycle pop. A pop does not enable a push in the same cycle.
- Overlapping report: hid_valid with busy=1 drops the report and sets report_dropped. The in-progress scan is unaffected.
- Event order per report: releases in slot order, then presses in slot order, then modifiers in bit order 0..7.
- FIFO handshake:
  - A pushed event is visible at the output (event_valid=1) the cycle after the push.
  - Pop occurs when event_valid && event_ready.
  - event_code and event_press are stable while event_valid=1 and event_ready=0.
- Empty slot: value 0x00 always; also 0x01..0x03 when C_ignore_err_codes=1.
- Index counters are 3 bits and are reset on each state entry. No wrap-around is used.

Decomposition:
- Package hid_kbd_pkg:
  - KEY_SLOTS=6, MOD_BITS=8
  - MOD_CODE_BASE=8'hE0, ERR_ROLLOVER=8'h01
  - EVENT_W=9, event field positions {press, code}
  - FSM state encoding
- Sub-module hid_event_fifo: synchronous FIFO, EVENT_W wide, C_fifo_depth deep, with full/empty flags and occupancy count.

Test Plan:
1. Press then release of A:
   - Report byte2=0x04 -> one event {press=1, code=0x04}.
   - Then an all-zero report -> {0, 0x04}.
   - No other events; busy=21 cycles each.
2. Modifier with key: byte0=0x02, byte2=0x05 -> events {1,0x05} then {1,0xE1}; modifiers=0x02 after COMMIT.
3. Rollover:
   - Hold key 0x04, then send bytes2..7 all 0x01 -> no events, rollover_err pulse, modifiers unchanged.
   - A following zero report -> {0,0x04}.
4. Backpressure and drop:
   - Hold event_ready=0; send byte0=0xFF with slots 0x04..0x09 (14 events) at depth 8.
   - FIFO fills to 8 and busy stays 1.
   - A second hid_valid sets report_dropped=1.
   - Releasing ready drains all 14 events in the specified order with no loss or duplicates.
5. Duplicate and error slots: slots {0x04,0x04,0x02,0,0,0} -> exactly one event {1,0x04}.
6. Reset mid-scan: assert reset during SCAN_PRS -> next cycle event_valid=0, busy=0, modifiers=0; a subsequent report is decoded against an all-zero prev.
